// File: rtl/refill_pkg.sv
// Shared state encoding and constants for the cache refill arbiter and its
// round-robin picker.
package refill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int   LINE_BYTES = 64;
    localparam int   BEAT_BYTES = 8;

    localparam logic IC = 1'b0;
    localparam logic DC = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins; on a tie the
// requester that was not served last wins. grant is one-hot (or zero).
module rr_arb2
    import refill_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == DC) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/cache_refill_arb.sv
// Arbitrates icache/dcache line refills onto one AXI read port (IDLE/ADDR/DATA).
// Define REFILL_ARB_TIMEOUT_EN to abort a DATA phase after 255 beat-less cycles.
module cache_refill_arb
    import refill_pkg::*;
#(
    parameter int BEATS  = 8,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_rvalid,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    output logic              dc_gnt,
    output logic              dc_rvalid,
    output logic              dc_done,
    output logic [63:0]       rdata,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [7:0]        ar_len,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [63:0]       r_data,
    input  logic              r_last,
    output logic              err
);

    localparam int                BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic              r_last_id;
    logic [ADDR_W-1:0] r_addr;
    logic [BW-1:0]     r_beat;
    logic              r_err;
    logic [1:0]        w_grant;
    logic              w_final;
    logic              w_beat;
    logic              w_done;
    logic              w_set_err;
`ifdef REFILL_ARB_TIMEOUT_EN
    logic [7:0]        r_tmo;
`endif

    rr_arb2 u_rr (
        .req   ({dc_req, ic_req}),
        .last  (r_last_id),
        .grant (w_grant)
    );

    assign w_final = (r_beat == BW'(BEATS - 1));

    always_comb begin
        w_next    = r_state;
        w_beat    = 1'b0;
        w_done    = 1'b0;
        w_set_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (ic_req || dc_req) w_next = ADDR;
            end
            ADDR: begin
                if (ar_ready) w_next = DATA;
            end
            DATA: begin
                if (r_valid) begin
                    w_beat = 1'b1;
                    // Early r_last and missing r_last are both protocol errors.
                    if (r_last != w_final) w_set_err = 1'b1;
                    if (w_final) begin
                        w_done = 1'b1;
                        w_next = IDLE;
                    end
                end
`ifdef REFILL_ARB_TIMEOUT_EN
                else if (r_tmo == 8'd254) begin
                    w_done    = 1'b1;
                    w_set_err = 1'b1;
                    w_next    = IDLE;
                end
`endif
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= IC;
            r_last_id <= DC;
            r_addr    <= '0;
            r_beat    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_err) r_err <= 1'b1;
            if (r_state == IDLE && w_grant != 2'b00) begin
                r_owner <= w_grant[DC];
                r_addr  <= w_grant[DC] ? dc_addr : ic_addr;
            end
            if (w_done) begin
                r_beat    <= '0;
                r_last_id <= r_owner;
            end else if (w_beat) begin
                r_beat <= r_beat + BW'(1);
            end
        end
    end

`ifdef REFILL_ARB_TIMEOUT_EN
    // Counts consecutive beat-less DATA cycles; any beat or exit clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (r_state == DATA && !r_valid && !w_done) begin
            r_tmo <= r_tmo + 8'd1;
        end else begin
            r_tmo <= '0;
        end
    end
`endif

    assign ic_gnt    = (r_state != IDLE) && (r_owner == IC);
    assign dc_gnt    = (r_state != IDLE) && (r_owner == DC);
    assign ic_rvalid = w_beat && (r_owner == IC);
    assign dc_rvalid = w_beat && (r_owner == DC);
    assign ic_done   = w_done && (r_owner == IC);
    assign dc_done   = w_done && (r_owner == DC);
    assign rdata     = r_data;
    assign ar_valid  = (r_state == ADDR);
    assign ar_addr   = r_addr & LINE_MASK;
    assign ar_len    = 8'(BEATS - 1);
    assign r_ready   = (r_state == DATA);
    assign err       = r_err;

endmodule

// File: tb/tb_cache_refill_arb.sv
// Scoreboard bench for cache_refill_arb: directed bursts push expected AR and
// beat events; a negedge monitor pops and compares them as the DUT emits them.
module tb_cache_refill_arb;
    import refill_pkg::*;

    localparam int BEATS = 8;

    typedef struct {
        logic        owner;
        logic [63:0] addr;
        logic [7:0]  len;
    } arExp_t;

    typedef struct {
        logic        owner;
        logic        rv;
        logic [63:0] data;
        logic        done;
    } beatExp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req, dc_req;
    logic [63:0] ic_addr, dc_addr;
    logic        ic_gnt, ic_rvalid, ic_done;
    logic        dc_gnt, dc_rvalid, dc_done;
    logic [63:0] rdata;
    logic        ar_valid, ar_ready;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic        r_valid, r_ready, r_last;
    logic [63:0] r_data;
    logic        err;

    int       nCompared = 0;
    int       nMismatched = 0;
    arExp_t   arQ[$];
    beatExp_t beatQ[$];
    arExp_t   ae;
    beatExp_t be;
    int       waited;

    cache_refill_arb #(.BEATS(BEATS), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
        .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_gnt(dc_gnt),
        .dc_rvalid(dc_rvalid), .dc_done(dc_done),
        .rdata(rdata),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportUnexpected(input string name);
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL %s: DUT output with empty expectation queue at %0t", name, $time);
    endtask

    task automatic expectBurst(input logic owner, input logic [63:0] alignedAddr,
                               input logic [63:0] seed, input int nBeats, input logic doneLast);
        arQ.push_back('{owner, alignedAddr, 8'd7});
        for (int i = 0; i < nBeats; i++) begin
            beatQ.push_back('{owner, 1'b1, seed + 64'(i), doneLast && (i == nBeats - 1)});
        end
    endtask

    // Acts as the AXI slave for one burst; returns cycles spent waiting for ar_valid.
    task automatic applyStimulus(input logic owner, input int stall, input int lastBeat,
                                 input logic [63:0] seed, input int preWait, output int nWait);
        logic [63:0] a0;
        int n = 0;
        while (!ar_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        nWait = n;
        checkOutput("ar_valid_seen", ar_valid, 1);
        a0 = ar_addr;
        repeat (stall) begin
            @(posedge clk); #1;
            checkOutput("ar_stall_valid", ar_valid, 1);
            checkOutput("ar_stall_addr", ar_addr, a0);
        end
        ar_ready = 1'b1;
        @(posedge clk); #1;
        ar_ready = 1'b0;
        checkOutput("data_entry", {ar_valid, r_ready}, 2'b01);
        checkOutput("owner_gnt", owner ? {dc_gnt, ic_gnt} : {ic_gnt, dc_gnt}, 2'b10);
        if (preWait > 0) begin
            repeat (preWait) begin
                @(posedge clk); #1;
            end
            checkOutput("no_timeout_still_data", r_ready, 1);
        end
        for (int i = 0; i < BEATS; i++) begin
            r_valid = 1'b1;
            r_data  = seed + 64'(i);
            r_last  = (i == lastBeat);
            @(posedge clk); #1;
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_data  = '0;
        checkOutput("burst_end_idle", {ic_gnt, dc_gnt, r_ready}, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) checkOutput("one_gnt", ic_gnt & dc_gnt, 0);
        if (ar_valid && ar_ready) begin
            if (arQ.size() == 0) begin
                reportUnexpected("ar_handshake");
            end else begin
                ae = arQ.pop_front();
                checkOutput("ar_addr", ar_addr, ae.addr);
                checkOutput("ar_len", ar_len, ae.len);
                checkOutput("ar_owner", {ic_gnt, dc_gnt}, ae.owner ? 2'b01 : 2'b10);
            end
        end
        if (ic_rvalid || dc_rvalid || ic_done || dc_done) begin
            if (beatQ.size() == 0) begin
                reportUnexpected("beat");
            end else begin
                be = beatQ.pop_front();
                checkOutput("beat_owner", dc_rvalid | dc_done, be.owner);
                checkOutput("beat_rvalid", be.owner ? dc_rvalid : ic_rvalid, be.rv);
                if (be.rv) checkOutput("beat_rdata", rdata, be.data);
                checkOutput("beat_done", be.owner ? dc_done : ic_done, be.done);
                checkOutput("beat_other_quiet",
                            be.owner ? (ic_rvalid | ic_done) : (dc_rvalid | dc_done), 0);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        ic_req = 1'b0; dc_req = 1'b0; ic_addr = '0; dc_addr = '0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, ic_done, dc_done, ar_valid, r_ready, err}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Simultaneous requests from reset: icache first, dcache after a one-cycle gap.
        ic_addr = 64'h0000_0000_1000_007F; dc_addr = 64'h0000_0000_2000_0001;
        ic_req = 1'b1; dc_req = 1'b1;
        expectBurst(IC, 64'h0000_0000_1000_0040, 64'h1111_0000_0000_0000, BEATS, 1'b1);
        expectBurst(DC, 64'h0000_0000_2000_0000, 64'h2222_0000_0000_0000, BEATS, 1'b1);
        applyStimulus(IC, 0, 7, 64'h1111_0000_0000_0000, 0, waited);
        ic_req = 1'b0;
        checkOutput("gap_no_gnt", {ic_gnt, dc_gnt, ar_valid}, 0);
        applyStimulus(DC, 0, 7, 64'h2222_0000_0000_0000, 0, waited);
        checkOutput("gap_one_cycle", 64'(waited), 1);
        dc_req = 1'b0;

        // Lone icache request, unaligned address.
        ic_addr = 64'h0000_0000_8000_0044;
        ic_req = 1'b1;
        expectBurst(IC, 64'h0000_0000_8000_0040, 64'h3333_0000_0000_0000, BEATS, 1'b1);
        @(posedge clk); #1;
        checkOutput("grant_latency", {ic_gnt, dc_gnt, ar_valid}, 3'b101);
        applyStimulus(IC, 0, 7, 64'h3333_0000_0000_0000, 0, waited);
        ic_req = 1'b0;

        // Both again after an icache burst: dcache goes first.
        dc_addr = 64'h0000_0000_3000_00FF; ic_addr = 64'h0000_0000_4000_0010;
        ic_req = 1'b1; dc_req = 1'b1;
        expectBurst(DC, 64'h0000_0000_3000_00C0, 64'h4444_0000_0000_0000, BEATS, 1'b1);
        expectBurst(IC, 64'h0000_0000_4000_0000, 64'h5555_0000_0000_0000, BEATS, 1'b1);
        applyStimulus(DC, 0, 7, 64'h4444_0000_0000_0000, 0, waited);
        dc_req = 1'b0;
        applyStimulus(IC, 0, 7, 64'h5555_0000_0000_0000, 0, waited);
        ic_req = 1'b0;

        // AR stalled five cycles, then a lone dcache wins against the pointer.
        dc_addr = 64'h1234_5678_9ABC_DEF7;
        dc_req = 1'b1;
        expectBurst(DC, 64'h1234_5678_9ABC_DEC0, 64'h6666_0000_0000_0000, BEATS, 1'b1);
        applyStimulus(DC, 5, 7, 64'h6666_0000_0000_0000, 0, waited);
        dc_req = 1'b0;
        dc_addr = 64'h0000_0000_5000_0040;
        dc_req = 1'b1;
        expectBurst(DC, 64'h0000_0000_5000_0040, 64'h7777_0000_0000_0000, BEATS, 1'b1);
        applyStimulus(DC, 0, 7, 64'h7777_0000_0000_0000, 0, waited);
        dc_req = 1'b0;

        // Early r_last on the fourth beat: err sets, burst still runs to 8 beats.
        checkOutput("err_clear_before", err, 0);
        ic_addr = 64'h0000_0000_6000_0088;
        ic_req = 1'b1;
        expectBurst(IC, 64'h0000_0000_6000_0080, 64'h8888_0000_0000_0000, BEATS, 1'b1);
        applyStimulus(IC, 0, 3, 64'h8888_0000_0000_0000, 0, waited);
        ic_req = 1'b0;
        checkOutput("err_sticky_set", err, 1);

        // Reset on the third beat abandons the burst without a done pulse.
        ic_addr = 64'h0000_0000_7000_0000;
        ic_req = 1'b1;
        expectBurst(IC, 64'h0000_0000_7000_0000, 64'h9999_0000_0000_0000, 3, 1'b0);
        waited = 0;
        while (!ar_valid && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        ar_ready = 1'b1;
        @(posedge clk); #1;
        ar_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r_valid = 1'b1;
            r_data  = 64'h9999_0000_0000_0000 + 64'(i);
            @(posedge clk); #1;
        end
        r_data = 64'h9999_0000_0000_0002;
        rst = 1'b1;
        ic_req = 1'b0;
        @(posedge clk); #1;
        r_valid = 1'b0;
        checkOutput("rst_mid_outputs",
                    {ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, ic_done, dc_done, ar_valid, r_ready, err}, 0);
        rst = 1'b0;
        ic_addr = 64'h0000_0000_9000_0005; dc_addr = 64'h0000_0000_A000_007E;
        ic_req = 1'b1; dc_req = 1'b1;
        expectBurst(IC, 64'h0000_0000_9000_0000, 64'hAAAA_0000_0000_0000, BEATS, 1'b1);
        expectBurst(DC, 64'h0000_0000_A000_0040, 64'hBBBB_0000_0000_0000, BEATS, 1'b1);
        applyStimulus(IC, 0, 7, 64'hAAAA_0000_0000_0000, 0, waited);
        ic_req = 1'b0;
        applyStimulus(DC, 0, 7, 64'hBBBB_0000_0000_0000, 0, waited);
        dc_req = 1'b0;
        checkOutput("err_after_rst", err, 0);

`ifdef REFILL_ARB_TIMEOUT_EN
        // Silent read channel: the owner gets a done without rvalid and err sets.
        ic_addr = 64'h0000_0000_B000_0000;
        ic_req = 1'b1;
        arQ.push_back('{IC, 64'h0000_0000_B000_0000, 8'd7});
        beatQ.push_back('{IC, 1'b0, 64'h0, 1'b1});
        waited = 0;
        while (!ar_valid && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        ar_ready = 1'b1;
        @(posedge clk); #1;
        ar_ready = 1'b0;
        waited = 1;
        while (!ic_done && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("tmo_cycles", 64'(waited), 255);
        ic_req = 1'b0;
        @(posedge clk); #1;
        checkOutput("tmo_err", err, 1);
        checkOutput("tmo_idle", {ic_gnt, r_ready}, 0);
`else
        // Without the timeout, DATA waits indefinitely for beats.
        ic_addr = 64'h0000_0000_B000_0000;
        ic_req = 1'b1;
        expectBurst(IC, 64'h0000_0000_B000_0000, 64'hCCCC_0000_0000_0000, BEATS, 1'b1);
        applyStimulus(IC, 0, 7, 64'hCCCC_0000_0000_0000, 300, waited);
        ic_req = 1'b0;
        checkOutput("no_timeout_err", err, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("ar_queue_drained", 64'(arQ.size()), 0);
        checkOutput("beat_queue_drained", 64'(beatQ.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
